clk_div_core: RTL and testbench

//  Programmable clock-divider engine fed by the clk_div AXI4-Lite register file.

---
 rtl/clk_div_pkg.sv | 48 ++++
 rtl/clk_div_if.sv | 25 ++
 rtl/clk_div_shadow.sv | 108 ++++++++++
 rtl/clk_div_core.sv | 139 +++++++++++++
 tb/tb_clk_div_core.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/clk_div_pkg.sv
// Shared types, defaults and the configuration clamp for the clk_div engine.
// The clamp works on a wide word so any counter width up to CFG_W_MAX can reuse it.
package clk_div_pkg;

    localparam int CNT_W_DEF   = 32;
    localparam int MIN_DIV_DEF = 2;
    localparam int CFG_W_MAX   = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        STOP = 2'd3
    } state_t;

    typedef struct packed {
        logic [CFG_W_MAX-1:0] div;
        logic [CFG_W_MAX-1:0] high;
        logic                 err;
    } clamp_t;

    // High time is clamped against the already-clamped period so it always leaves a low phase.
    function automatic clamp_t clamp_cfg(input logic [CFG_W_MAX-1:0] div,
                                         input logic [CFG_W_MAX-1:0] high,
                                         input logic [CFG_W_MAX-1:0] min_div);
        clamp_t res;
        res.div  = div;
        res.high = high;
        res.err  = 1'b0;
        if (div < min_div) begin
            res.div = min_div;
            res.err = 1'b1;
        end else begin
            res.div = div;
        end
        if (high == {CFG_W_MAX{1'b0}}) begin
            res.high = {{(CFG_W_MAX-1){1'b0}}, 1'b1};
            res.err  = 1'b1;
        end else if (high >= res.div) begin
            res.high = res.div - {{(CFG_W_MAX-1){1'b0}}, 1'b1};
            res.err  = 1'b1;
        end else begin
            res.high = high;
        end
        return res;
    endfunction

endpackage

// File: rtl/clk_div_if.sv
// Configuration/status bundle between the clk_div register file (master) and the divider core (slave).
interface clk_div_if #(
    parameter int CNT_W = 32
);
    logic             cfg_enable;
    logic             cfg_restart;
    logic             cfg_update;
    logic [CNT_W-1:0] cfg_div;
    logic [CNT_W-1:0] cfg_high;
    logic             clk_out;
    logic             clk_ce;
    logic             busy;
    logic             cfg_err;
    logic [CNT_W-1:0] edge_cnt;

    modport master (
        output cfg_enable, cfg_restart, cfg_update, cfg_div, cfg_high,
        input  clk_out, clk_ce, busy, cfg_err, edge_cnt
    );

    modport slave (
        input  cfg_enable, cfg_restart, cfg_update, cfg_div, cfg_high,
        output clk_out, clk_ce, busy, cfg_err, edge_cnt
    );
endinterface

// File: rtl/clk_div_shadow.sv
// Pending/shadow configuration pair: clamps on capture, moves pending into the shadows only at
// period boundaries or on restart, and keeps the sticky clamp-error flag.
module clk_div_shadow
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int MIN_DIV = MIN_DIV_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_update,
    input  logic [CNT_W-1:0] i_div,
    input  logic [CNT_W-1:0] i_high,
    input  logic             i_bnd_load,
    input  logic             i_rst_load,
    input  logic             i_err_clr,
    output logic [CNT_W-1:0] o_div_s,
    output logic [CNT_W-1:0] o_high_s,
    output logic [CNT_W-1:0] o_high_nxt,
    output logic             o_cfg_err
);

    clamp_t           w_clamp;
    logic [CNT_W-1:0] w_cl_div;
    logic [CNT_W-1:0] w_cl_high;
    logic [CNT_W-1:0] w_div_nxt;
    logic [CNT_W-1:0] w_high_nxt;

    logic [CNT_W-1:0] r_pend_div;
    logic [CNT_W-1:0] r_pend_high;
    logic             r_pend_v;
    logic [CNT_W-1:0] r_div_s;
    logic [CNT_W-1:0] r_high_s;
    logic             r_err;

    assign w_clamp   = clamp_cfg(CFG_W_MAX'(i_div), CFG_W_MAX'(i_high), CFG_W_MAX'(MIN_DIV));
    assign w_cl_div  = w_clamp.div[CNT_W-1:0];
    assign w_cl_high = w_clamp.high[CNT_W-1:0];

    // Next shadow values; a restart takes a same-cycle update directly, a wrap only takes what was already pending.
    always_comb begin
        w_div_nxt  = r_div_s;
        w_high_nxt = r_high_s;
        if (i_rst_load) begin
            if (i_update) begin
                w_div_nxt  = w_cl_div;
                w_high_nxt = w_cl_high;
            end else if (r_pend_v) begin
                w_div_nxt  = r_pend_div;
                w_high_nxt = r_pend_high;
            end else begin
                w_div_nxt  = r_div_s;
                w_high_nxt = r_high_s;
            end
        end else if (i_bnd_load && r_pend_v) begin
            w_div_nxt  = r_pend_div;
            w_high_nxt = r_pend_high;
        end else begin
            w_div_nxt  = r_div_s;
            w_high_nxt = r_high_s;
        end
    end

    // Pending, shadow and error registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pend_div  <= {CNT_W{1'b0}};
            r_pend_high <= {CNT_W{1'b0}};
            r_pend_v    <= 1'b0;
            r_div_s     <= CNT_W'(MIN_DIV);
            r_high_s    <= CNT_W'(1'b1);
            r_err       <= 1'b0;
        end else begin
            r_div_s  <= w_div_nxt;
            r_high_s <= w_high_nxt;
            if (i_update) begin
                r_pend_div  <= w_cl_div;
                r_pend_high <= w_cl_high;
            end else begin
                r_pend_div  <= r_pend_div;
                r_pend_high <= r_pend_high;
            end
            if (i_rst_load) begin
                r_pend_v <= 1'b0;
            end else if (i_update) begin
                r_pend_v <= 1'b1;
            end else if (i_bnd_load) begin
                r_pend_v <= 1'b0;
            end else begin
                r_pend_v <= r_pend_v;
            end
            // A fresh clamp wins over a simultaneous clear so the new error is not lost.
            if (i_update && w_clamp.err) begin
                r_err <= 1'b1;
            end else if (i_err_clr) begin
                r_err <= 1'b0;
            end else begin
                r_err <= r_err;
            end
        end
    end

    assign o_div_s    = r_div_s;
    assign o_high_s   = r_high_s;
    assign o_high_nxt = w_high_nxt;
    assign o_cfg_err  = r_err;

endmodule

// File: rtl/clk_div_core.sv
// Programmable clock divider: FSM plus period counter, producing a registered clk_out and clk_ce.
// Optional rising-edge counter enabled by defining CLK_DIV_EDGE_CNT_EN.
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int MIN_DIV = MIN_DIV_DEF
) (
    input  logic     ACLK,
    input  logic     ARESET,
    clk_div_if.slave bus
);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_clk_out;
    logic             r_clk_ce;
    logic             r_busy;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_bnd_load;
    logic             w_rst_load;
    logic             w_last;
    logic             w_clk_out_nxt;
    logic             w_ce_nxt;
    logic [CNT_W-1:0] w_div_s;
    logic [CNT_W-1:0] w_high_s;
    logic [CNT_W-1:0] w_high_nxt;
    logic             w_cfg_err;

    clk_div_shadow #(
        .CNT_W   (CNT_W),
        .MIN_DIV (MIN_DIV)
    ) u_shadow (
        .i_clk      (ACLK),
        .i_rst      (ARESET),
        .i_update   (bus.cfg_update),
        .i_div      (bus.cfg_div),
        .i_high     (bus.cfg_high),
        .i_bnd_load (w_bnd_load),
        .i_rst_load (w_rst_load),
        .i_err_clr  (bus.cfg_restart),
        .o_div_s    (w_div_s),
        .o_high_s   (w_high_s),
        .o_high_nxt (w_high_nxt),
        .o_cfg_err  (w_cfg_err)
    );

    assign w_last = (r_cnt == (w_div_s - CNT_W'(1'b1)));

    // Next state/count; outputs are computed from the next values so the registers line up with cnt.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bnd_load  = 1'b0;
        w_rst_load  = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt   = {CNT_W{1'b0}};
                w_state_nxt = bus.cfg_enable ? LOAD : IDLE;
            end
            LOAD: begin
                w_cnt_nxt   = {CNT_W{1'b0}};
                w_bnd_load  = 1'b1;
                w_state_nxt = RUN;
            end
            RUN, STOP: begin
                if (bus.cfg_restart) begin
                    w_cnt_nxt   = {CNT_W{1'b0}};
                    w_rst_load  = 1'b1;
                    w_state_nxt = bus.cfg_enable ? RUN : STOP;
                end else if (w_last) begin
                    // End of period: either continue with any pending config or stop cleanly.
                    w_cnt_nxt = {CNT_W{1'b0}};
                    if (bus.cfg_enable) begin
                        w_bnd_load  = 1'b1;
                        w_state_nxt = RUN;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1'b1);
                    w_state_nxt = bus.cfg_enable ? RUN : STOP;
                end
            end
            default: begin
                w_cnt_nxt   = {CNT_W{1'b0}};
                w_state_nxt = IDLE;
            end
        endcase
        w_clk_out_nxt = ((w_state_nxt == RUN) || (w_state_nxt == STOP)) && (w_cnt_nxt < w_high_nxt);
        w_ce_nxt      = (w_state_nxt == RUN) && (w_cnt_nxt == {CNT_W{1'b0}});
    end

    // State, counter and registered outputs.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state   <= IDLE;
            r_cnt     <= {CNT_W{1'b0}};
            r_clk_out <= 1'b0;
            r_clk_ce  <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_clk_out <= w_clk_out_nxt;
            r_clk_ce  <= w_ce_nxt;
            r_busy    <= (w_state_nxt != IDLE);
        end
    end

`ifdef CLK_DIV_EDGE_CNT_EN
    logic [CNT_W-1:0] r_edge_cnt;

    // Rising-edge counter; a restart clears it but still counts an edge produced by the restart itself.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_edge_cnt <= {CNT_W{1'b0}};
        end else if (bus.cfg_restart) begin
            r_edge_cnt <= w_ce_nxt ? CNT_W'(1'b1) : {CNT_W{1'b0}};
        end else if (w_ce_nxt) begin
            r_edge_cnt <= r_edge_cnt + CNT_W'(1'b1);
        end else begin
            r_edge_cnt <= r_edge_cnt;
        end
    end

    assign bus.edge_cnt = r_edge_cnt;
`else
    assign bus.edge_cnt = {CNT_W{1'b0}};
`endif

    assign bus.clk_out = r_clk_out;
    assign bus.clk_ce  = r_clk_ce;
    assign bus.busy    = r_busy;
    assign bus.cfg_err = w_cfg_err;

endmodule

// File: tb/tb_clk_div_core.sv
// Directed bench for clk_div_core: latency, patterns, clamps, boundary updates, stop, restart, reset.
module tb_clk_div_core;

`ifdef CLK_DIV_EDGE_CNT_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic areset;
    int   n_vec = 0;
    int   n_err = 0;

    clk_div_if #(.CNT_W(32)) bus ();

    clk_div_core #(.CNT_W(32), .MIN_DIV(2)) dut (
        .ACLK   (clk),
        .ARESET (areset),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input logic [31:0] d, input logic [31:0] h);
        bus.cfg_div    = d;
        bus.cfg_high   = h;
        bus.cfg_update = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        areset          = 1'b1;
        bus.cfg_enable  = 1'b0;
        bus.cfg_restart = 1'b0;
        bus.cfg_update  = 1'b0;
        bus.cfg_div     = 32'd0;
        bus.cfg_high    = 32'd0;
        step();
        step();
        areset = 1'b0;
        chk1("rst_clk_out", bus.clk_out, 1'b0);
        chk1("rst_clk_ce", bus.clk_ce, 1'b0);
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_cfg_err", bus.cfg_err, 1'b0);
        chkw("rst_edge_cnt", bus.edge_cnt, 32'd0);

        // div=4 high=2: LOAD cycle then 1100 repeating
        set_cfg(32'd4, 32'd2);
        step();
        bus.cfg_update = 1'b0;
        chk1("d4_err", bus.cfg_err, 1'b0);
        bus.cfg_enable = 1'b1;
        step();
        chk1("load_busy", bus.busy, 1'b1);
        chk1("load_clk_out", bus.clk_out, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step();
            chk1("d4_clk_out", bus.clk_out, (i % 4) < 2);
            chk1("d4_clk_ce", bus.clk_ce, (i % 4) == 0);
        end

        // update to 6/3 sampled at cnt=1: current period stays 4
        step();
        chk1("upd_cnt0", bus.clk_out, 1'b1);
        step();
        chk1("upd_cnt1", bus.clk_out, 1'b1);
        set_cfg(32'd6, 32'd3);
        for (int i = 0; i < 14; i++) begin
            step();
            bus.cfg_update = 1'b0;
            if (i < 2) begin
                chk1("upd_tail", bus.clk_out, 1'b0);
                chk1("upd_tail_ce", bus.clk_ce, 1'b0);
            end else begin
                chk1("d6_clk_out", bus.clk_out, ((i - 2) % 6) < 3);
                chk1("d6_clk_ce", bus.clk_ce, ((i - 2) % 6) == 0);
            end
        end

        // restart together with update to 8/4 applies the new values immediately
        set_cfg(32'd8, 32'd4);
        bus.cfg_restart = 1'b1;
        step();
        bus.cfg_update  = 1'b0;
        bus.cfg_restart = 1'b0;
        chk1("rs8_clk_out", bus.clk_out, 1'b1);
        chk1("rs8_clk_ce", bus.clk_ce, 1'b1);
        chk1("rs8_err", bus.cfg_err, 1'b0);
        step();
        chk1("d8_cnt1", bus.clk_out, 1'b1);
        bus.cfg_enable = 1'b0;
        for (int c = 2; c < 8; c++) begin
            step();
            chk1("stop_clk_out", bus.clk_out, c < 4);
            chk1("stop_clk_ce", bus.clk_ce, 1'b0);
            chk1("stop_busy", bus.busy, 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            chk1("idle_busy", bus.busy, 1'b0);
            chk1("idle_clk_out", bus.clk_out, 1'b0);
            chk1("idle_clk_ce", bus.clk_ce, 1'b0);
        end

        // div=0 high=0 clamps to 2/1: 10 repeating
        set_cfg(32'd0, 32'd0);
        step();
        bus.cfg_update = 1'b0;
        chk1("clamp0_err", bus.cfg_err, 1'b1);
        bus.cfg_enable = 1'b1;
        step();
        chk1("clamp0_load", bus.clk_out, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk1("d2_clk_out", bus.clk_out, (i % 2) == 0);
            chk1("d2_clk_ce", bus.clk_ce, (i % 2) == 0);
        end

        // restart clears the error; 4/5 clamps high to 3 -> 1110
        bus.cfg_restart = 1'b1;
        step();
        bus.cfg_restart = 1'b0;
        chk1("rs_err_clr", bus.cfg_err, 1'b0);
        chk1("rs_clk_ce", bus.clk_ce, 1'b1);
        set_cfg(32'd4, 32'd5);
        bus.cfg_restart = 1'b1;
        step();
        bus.cfg_update  = 1'b0;
        bus.cfg_restart = 1'b0;
        chk1("clamp45_err", bus.cfg_err, 1'b1);
        chk1("clamp45_cnt0", bus.clk_out, 1'b1);
        for (int i = 1; i < 8; i++) begin
            step();
            chk1("d4h3_clk_out", bus.clk_out, (i % 4) < 3);
            chk1("d4h3_clk_ce", bus.clk_ce, (i % 4) == 0);
        end
        bus.cfg_restart = 1'b1;
        step();
        bus.cfg_restart = 1'b0;
        chk1("clamp45_clr", bus.cfg_err, 1'b0);
        chkw("edge_after_rs", bus.edge_cnt, EDGE_EN ? 32'd1 : 32'd0);
        for (int i = 0; i < 36; i++) begin
            step();
        end
        chk1("edge10_ce", bus.clk_ce, 1'b1);
        chkw("edge10", bus.edge_cnt, EDGE_EN ? 32'd10 : 32'd0);

        // reset mid-RUN with the error flag set
        step();
        set_cfg(32'd0, 32'd0);
        step();
        bus.cfg_update = 1'b0;
        chk1("pre_rst_err", bus.cfg_err, 1'b1);
        chk1("pre_rst_busy", bus.busy, 1'b1);
        areset = 1'b1;
        step();
        chk1("mrst_clk_out", bus.clk_out, 1'b0);
        chk1("mrst_clk_ce", bus.clk_ce, 1'b0);
        chk1("mrst_busy", bus.busy, 1'b0);
        chk1("mrst_err", bus.cfg_err, 1'b0);
        chkw("mrst_edge", bus.edge_cnt, 32'd0);
        areset         = 1'b0;
        bus.cfg_enable = 1'b0;
        step();
        chk1("post_rst_busy", bus.busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
